// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler and its command FIFO.
package draw_pkg;

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      CIRCLE   = 2'd1,
      REULEAUX = 2'd2,
      RESERVED = 2'd3
   } shape_e;

   typedef struct packed {
      shape_e      shape;
      logic [2:0]  colour;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [7:0]  diameter;
   } draw_cmd_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      RELEASE = 2'd2
   } sched_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of draw commands; full/empty come from pointers that carry
// one extra wrap bit.
module cmd_fifo
   import draw_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  draw_cmd_t data_i,
   input  logic      pop_i,
   output draw_cmd_t data_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   draw_cmd_t   mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/draw_scheduler.sv
// Queues draw commands, launches one engine at a time and muxes its plot stream
// to the VGA port. Define DRAW_SCHED_CLIP_EN to suppress off-screen plots.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_ENG    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_shape,
   input  logic [2:0]           cmd_colour,
   input  logic [7:0]           cmd_x,
   input  logic [6:0]           cmd_y,
   input  logic [7:0]           cmd_diameter,
   output logic [NUM_ENG-1:0]   eng_start,
   input  logic [NUM_ENG-1:0]   eng_done,
   output logic [2:0]           eng_colour,
   output logic [7:0]           eng_centre_x,
   output logic [6:0]           eng_centre_y,
   output logic [7:0]           eng_diameter,
   input  logic [NUM_ENG*8-1:0] eng_vga_x,
   input  logic [NUM_ENG*7-1:0] eng_vga_y,
   input  logic [NUM_ENG*3-1:0] eng_vga_colour,
   input  logic [NUM_ENG-1:0]   eng_vga_plot,
   output logic [7:0]           vga_x,
   output logic [6:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 vga_plot,
   output logic                 busy,
   output logic                 err_shape
);

   draw_cmd_t    push_cmd, head;
   logic         fifo_full, fifo_empty, pop;
   logic         shape_ok, done_act, in_bounds;

   sched_state_e state_q, state_d;
   logic [1:0]   active_q, active_d;
   logic [2:0]   colour_q, colour_d;
   logic [7:0]   cx_q, cx_d;
   logic [6:0]   cy_q, cy_d;
   logic [7:0]   diam_q, diam_d;
   logic         err_q, err_d;

   logic [7:0]   sel_x, vga_x_q, vga_x_d;
   logic [6:0]   sel_y, vga_y_q, vga_y_d;
   logic [2:0]   sel_col, vga_col_q, vga_col_d;
   logic         sel_plot, vga_plot_q, vga_plot_d;

   assign push_cmd = '{shape: shape_e'(cmd_shape), colour: cmd_colour,
                       x: cmd_x, y: cmd_y, diameter: cmd_diameter};

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_valid),
      .data_i  (push_cmd),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign shape_ok  = (int'(head.shape) < NUM_ENG);
   assign pop       = (state_q == IDLE) && !fifo_empty;

   // Only the active engine's done, start and plot stream are ever looked at.
   always_comb begin
      done_act  = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_col   = '0;
      sel_plot  = 1'b0;
      eng_start = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (active_q == 2'(i)) begin
            done_act     = eng_done[i];
            sel_x        = eng_vga_x[i*8 +: 8];
            sel_y        = eng_vga_y[i*7 +: 7];
            sel_col      = eng_vga_colour[i*3 +: 3];
            sel_plot     = eng_vga_plot[i];
            eng_start[i] = (state_q == LAUNCH);
         end
      end
   end

`ifdef DRAW_SCHED_CLIP_EN
   assign in_bounds = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
`else
   assign in_bounds = 1'b1;
`endif

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      colour_d   = colour_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      diam_d     = diam_q;
      err_d      = 1'b0;
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      vga_col_d  = vga_col_q;
      vga_plot_d = 1'b0;

      if (pop) begin
         colour_d = head.colour;
         cx_d     = head.x;
         cy_d     = head.y;
         diam_d   = head.diameter;
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               if (shape_ok) begin
                  state_d  = LAUNCH;
                  active_d = head.shape;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LAUNCH: begin
            vga_x_d    = sel_x;
            vga_y_d    = sel_y;
            vga_col_d  = sel_col;
            vga_plot_d = sel_plot && in_bounds;
            if (done_act) state_d = RELEASE;
         end
         RELEASE: begin
            // Waits for done to drop so a sticky done cannot retrigger the next launch.
            if (!done_act) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         active_q   <= '0;
         colour_q   <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         diam_q     <= '0;
         err_q      <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         vga_col_q  <= '0;
         vga_plot_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         colour_q   <= colour_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         diam_q     <= diam_d;
         err_q      <= err_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         vga_col_q  <= vga_col_d;
         vga_plot_q <= vga_plot_d;
      end
   end

   assign eng_colour   = colour_q;
   assign eng_centre_x = cx_q;
   assign eng_centre_y = cy_q;
   assign eng_diameter = diam_q;
   assign vga_x        = vga_x_q;
   assign vga_y        = vga_y_q;
   assign vga_colour   = vga_col_q;
   assign vga_plot     = vga_plot_q;
   assign busy         = (state_q != IDLE) || !fifo_empty;
   assign err_shape    = err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_draw_scheduler;

   localparam int NE = 3;
`ifdef DRAW_SCHED_CLIP_EN
   localparam logic CLIP = 1'b1;
`else
   localparam logic CLIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_shape = '0;
   logic [2:0]    cmd_colour = '0;
   logic [7:0]    cmd_x = '0;
   logic [6:0]    cmd_y = '0;
   logic [7:0]    cmd_diameter = '0;
   logic [NE-1:0] eng_start;
   logic [NE-1:0] eng_done = '0;
   logic [2:0]    eng_colour;
   logic [7:0]    eng_centre_x;
   logic [6:0]    eng_centre_y;
   logic [7:0]    eng_diameter;
   logic [NE*8-1:0] eng_vga_x = '0;
   logic [NE*7-1:0] eng_vga_y = '0;
   logic [NE*3-1:0] eng_vga_colour = '0;
   logic [NE-1:0]   eng_vga_plot = '0;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot;
   logic          busy;
   logic          err_shape;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   draw_scheduler #(.FIFO_DEPTH(4), .NUM_ENG(NE)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_shape(cmd_shape),
      .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_diameter(cmd_diameter),
      .eng_start(eng_start), .eng_done(eng_done),
      .eng_colour(eng_colour), .eng_centre_x(eng_centre_x),
      .eng_centre_y(eng_centre_y), .eng_diameter(eng_diameter),
      .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y),
      .eng_vga_colour(eng_vga_colour), .eng_vga_plot(eng_vga_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .err_shape(err_shape)
   );

   task automatic set_cmd(input logic [1:0] s, input logic [2:0] c,
                          input logic [7:0] x, input logic [6:0] y, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_shape = s; cmd_colour = c;
      cmd_x = x; cmd_y = y; cmd_diameter = d;
   endtask

   task automatic set_plot(input int idx, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic p);
      eng_vga_x[idx*8 +: 8] = x;
      eng_vga_y[idx*7 +: 7] = y;
      eng_vga_colour[idx*3 +: 3] = c;
      eng_vga_plot[idx] = p;
   endtask

   // Returns the number of extra falling edges before a start appears, or -1.
   task automatic wait_start(output int cycles);
      cycles = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (eng_start != '0) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({cmd_ready, eng_start, busy, err_shape} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b want %b", {cmd_ready, eng_start, busy, err_shape}, 6'b100000);
      end
      tests_run++;
      if ({eng_colour, eng_centre_x, eng_centre_y, eng_diameter} !== 26'd0) begin
         tests_failed++;
         $display("FAIL reset_operands: got %h want 0", {eng_colour, eng_centre_x, eng_centre_y, eng_diameter});
      end
      tests_run++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0) begin
         tests_failed++;
         $display("FAIL reset_vga: got %h want 0", {vga_x, vga_y, vga_colour, vga_plot});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      set_cmd(2'd2, 3'b010, 8'd80, 7'd60, 8'd40);
      @(negedge clk);
      cmd_valid = 1'b0;
      tests_run++;
      if ({eng_start, busy} !== {3'b000, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_pop_cycle: got %b want %b", {eng_start, busy}, 4'b0001);
      end
      @(negedge clk);
      tests_run++;
      if (eng_start !== 3'b100) begin
         tests_failed++;
         $display("FAIL single_start: got %b want 100", eng_start);
      end
      tests_run++;
      if ({eng_colour, eng_centre_x, eng_centre_y, eng_diameter} !== {3'b010, 8'd80, 7'd60, 8'd40}) begin
         tests_failed++;
         $display("FAIL single_operands: got %h want %h", {eng_colour, eng_centre_x, eng_centre_y, eng_diameter},
                  {3'b010, 8'd80, 7'd60, 8'd40});
      end
      set_plot(2, 8'd10, 7'd20, 3'd5, 1'b1);
      set_plot(0, 8'd99, 7'd99, 3'd7, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd10, 7'd20, 3'd5, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_plot: got %h want %h", {vga_x, vga_y, vga_colour, vga_plot}, {8'd10, 7'd20, 3'd5, 1'b1});
      end
      set_plot(2, 8'd11, 7'd21, 3'd6, 1'b0);
      set_plot(0, 8'd0, 7'd0, 3'd0, 1'b0);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd11, 7'd21, 3'd6, 1'b0}) begin
         tests_failed++;
         $display("FAIL single_noplot: got %h want %h", {vga_x, vga_y, vga_colour, vga_plot}, {8'd11, 7'd21, 3'd6, 1'b0});
      end
      eng_done[2] = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({eng_start, busy} !== {3'b000, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_release: got %b want %b", {eng_start, busy}, 4'b0001);
      end
      set_plot(2, 8'd77, 7'd77, 3'd1, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_plot, eng_start, busy} !== {8'd11, 1'b0, 3'b000, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_hold: got %h want %h", {vga_x, vga_plot, eng_start, busy}, {8'd11, 1'b0, 3'b000, 1'b1});
      end
      eng_done[2] = 1'b0;
      set_plot(2, 8'd0, 7'd0, 3'd0, 1'b0);
      @(negedge clk);
      tests_run++;
      if ({busy, eng_start, eng_colour, eng_centre_x, eng_centre_y, eng_diameter} !==
          {1'b0, 3'b000, 3'b010, 8'd80, 7'd60, 8'd40}) begin
         tests_failed++;
         $display("FAIL single_idle: got %h want %h", {busy, eng_start, eng_colour, eng_centre_x, eng_centre_y, eng_diameter},
                  {1'b0, 3'b000, 3'b010, 8'd80, 7'd60, 8'd40});
      end
   endtask

   task automatic test_queue_full();
      int c;
      set_cmd(2'd0, 3'd1, 8'd1, 7'd1, 8'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_start(c);
      tests_run++;
      if (c < 0 || eng_start !== 3'b001 || eng_colour !== 3'd1) begin
         tests_failed++;
         $display("FAIL full_first_launch: got start %b colour %0d want 001 colour 1", eng_start, eng_colour);
      end
      for (int k = 2; k <= 5; k++) begin
         set_cmd(2'd0, 3'(k), 8'(k), 7'(k), 8'(k));
         @(negedge clk);
      end
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_ready_low: got %b want 0", cmd_ready);
      end
      set_cmd(2'd0, 3'd6, 8'd6, 7'd6, 8'd6);
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_refused: got %b want 0", cmd_ready);
      end
      eng_done[0] = 1'b1;
      @(negedge clk);
      eng_done[0] = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_before_pop: got %b want 0", cmd_ready);
      end
      @(negedge clk);
      tests_run++;
      if ({cmd_ready, eng_start, eng_colour} !== {1'b1, 3'b001, 3'd2}) begin
         tests_failed++;
         $display("FAIL full_after_pop: got %b want %b", {cmd_ready, eng_start, eng_colour}, {1'b1, 3'b001, 3'd2});
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      tests_run++;
      if (cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_fifth_accepted: got ready %b want 0", cmd_ready);
      end
      for (int k = 3; k <= 6; k++) begin
         eng_done[0] = 1'b1;
         @(negedge clk);
         eng_done[0] = 1'b0;
         wait_start(c);
         tests_run++;
         if (c < 0 || eng_start !== 3'b001 || eng_colour !== 3'(k)) begin
            tests_failed++;
            $display("FAIL full_order_%0d: got start %b colour %0d want 001 colour %0d", k, eng_start, eng_colour, k);
         end
      end
      eng_done[0] = 1'b1;
      @(negedge clk);
      eng_done[0] = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({busy, cmd_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL full_drained: got %b want 01", {busy, cmd_ready});
      end
   endtask

   task automatic test_reserved();
      set_cmd(2'd3, 3'd7, 8'd9, 7'd9, 8'd9);
      @(negedge clk);
      set_cmd(2'd1, 3'd4, 8'd33, 7'd44, 8'd55);
      @(negedge clk);
      cmd_valid = 1'b0;
      tests_run++;
      if ({err_shape, eng_start} !== {1'b1, 3'b000}) begin
         tests_failed++;
         $display("FAIL reserved_err: got %b want 1000", {err_shape, eng_start});
      end
      @(negedge clk);
      tests_run++;
      if ({err_shape, eng_start, eng_colour, eng_centre_x} !== {1'b0, 3'b010, 3'd4, 8'd33}) begin
         tests_failed++;
         $display("FAIL reserved_next: got %h want %h", {err_shape, eng_start, eng_colour, eng_centre_x},
                  {1'b0, 3'b010, 3'd4, 8'd33});
      end
   endtask

   // Runs straight after test_reserved, with the circle engine still in LAUNCH.
   task automatic test_spurious_done();
      eng_done = 3'b101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (eng_start !== 3'b010) begin
            tests_failed++;
            $display("FAIL spurious_launch_%0d: got %b want 010", i, eng_start);
         end
      end
      eng_done = 3'b111;
      @(negedge clk);
      tests_run++;
      if ({eng_start, busy} !== {3'b000, 1'b1}) begin
         tests_failed++;
         $display("FAIL spurious_release: got %b want 0001", {eng_start, busy});
      end
      eng_done = 3'b101;
      @(negedge clk);
      tests_run++;
      if ({eng_start, busy} !== {3'b000, 1'b0}) begin
         tests_failed++;
         $display("FAIL spurious_idle: got %b want 0000", {eng_start, busy});
      end
      eng_done = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_clip();
      int c;
      set_cmd(2'd0, 3'd2, 8'd0, 7'd0, 8'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_start(c);
      tests_run++;
      if (c < 0 || eng_start !== 3'b001) begin
         tests_failed++;
         $display("FAIL clip_launch: got %b want 001", eng_start);
      end
      set_plot(0, 8'd200, 7'd10, 3'd3, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_y, vga_plot} !== {8'd200, 7'd10, !CLIP}) begin
         tests_failed++;
         $display("FAIL clip_x_out: got %h want %h", {vga_x, vga_y, vga_plot}, {8'd200, 7'd10, !CLIP});
      end
      set_plot(0, 8'd159, 7'd119, 3'd3, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_y, vga_plot} !== {8'd159, 7'd119, 1'b1}) begin
         tests_failed++;
         $display("FAIL clip_corner: got %h want %h", {vga_x, vga_y, vga_plot}, {8'd159, 7'd119, 1'b1});
      end
      set_plot(0, 8'd5, 7'd120, 3'd3, 1'b1);
      @(negedge clk);
      tests_run++;
      if ({vga_x, vga_y, vga_plot} !== {8'd5, 7'd120, !CLIP}) begin
         tests_failed++;
         $display("FAIL clip_y_out: got %h want %h", {vga_x, vga_y, vga_plot}, {8'd5, 7'd120, !CLIP});
      end
      set_plot(0, 8'd0, 7'd0, 3'd0, 1'b0);
      eng_done[0] = 1'b1;
      @(negedge clk);
      eng_done[0] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int starts_seen;
      set_cmd(2'd1, 3'd1, 8'd1, 7'd1, 8'd1);
      @(negedge clk);
      set_cmd(2'd0, 3'd2, 8'd2, 7'd2, 8'd2);
      @(negedge clk);
      set_cmd(2'd2, 3'd3, 8'd3, 7'd3, 8'd3);
      @(negedge clk);
      cmd_valid = 1'b0;
      tests_run++;
      if ({eng_start, busy} !== {3'b010, 1'b1}) begin
         tests_failed++;
         $display("FAIL midreset_pre: got %b want 0101", {eng_start, busy});
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({eng_start, cmd_ready, busy} !== {3'b000, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL midreset_async: got %b want 00010", {eng_start, cmd_ready, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      starts_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (eng_start != '0 || busy) starts_seen++;
      end
      tests_run++;
      if (starts_seen !== 0) begin
         tests_failed++;
         $display("FAIL midreset_after: got %0d active cycles want 0", starts_seen);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_queue_full();
      test_reserved();
      test_spurious_done();
      test_clip();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
